// File: rtl/har_frame_loader_pkg.sv
// Shared types and defaults for the HAR classifier front end.
// Used by har_frame_loader_if and har_frame_loader.
package har_pkg;

  localparam int CLASS_W         = 4;
  localparam int IMG_SIZE_DEF    = 95;
  localparam int NUM_CLASSES_DEF = 6;

  typedef enum logic [2:0] {
    LOAD,
    DROP,
    FIRE,
    WAIT,
    OUT
  } state_t;

endpackage

// File: rtl/har_frame_loader_if.sv
// Sample stream, classifier and result bundle for har_frame_loader.
// slave = loader side, master = producer/classifier/consumer side.
interface har_frame_loader_if
  import har_pkg::*;
#(
  parameter int IMG_SIZE = IMG_SIZE_DEF,
  parameter int M        = 15
) ();

  logic                         s_valid;
  logic                         s_ready;
  logic [M:0]                   s_data;
  logic                         s_last;
  logic [IMG_SIZE-1:0][M:0]     image;
  logic                         v_valid;
  logic [CLASS_W-1:0]           class_in;
  logic                         m_valid;
  logic                         m_ready;
  logic [CLASS_W-1:0]           m_class;
  logic                         busy;
  logic                         frame_err;

  modport slave (
    input  s_valid, s_data, s_last, class_in, m_ready,
    output s_ready, image, v_valid, m_valid, m_class, busy, frame_err
  );

  modport master (
    output s_valid, s_data, s_last, class_in, m_ready,
    input  s_ready, image, v_valid, m_valid, m_class, busy, frame_err
  );

endinterface

// File: rtl/har_frame_loader.sv
// har_frame_loader: collects one frame of signed samples into the parallel
// image vector, strobes the crossbar classifier, samples its predicted class
// after a fixed latency and hands it out on a valid/ready port.
// Optional feature: define HAR_TIMEOUT_EN to abandon a partial frame that
// stalls for TIMEOUT cycles.
module har_frame_loader
  import har_pkg::*;
#(
  parameter int IMG_SIZE    = IMG_SIZE_DEF,
  parameter int NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int M           = 15,
  parameter int VALID_CYC   = 2,
  parameter int RESULT_LAT  = 1,
  parameter int TIMEOUT     = 1024
) (
  input logic               clk,
  input logic               rst,
  har_frame_loader_if.slave bus
);

  localparam int IDX_W = $clog2(IMG_SIZE);
  localparam int CNT_W = $clog2(VALID_CYC + RESULT_LAT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(IMG_SIZE - 1);
  localparam logic [CNT_W-1:0] FIRE_LAST = CNT_W'(VALID_CYC);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RESULT_LAT - 1);

  // Reject configurations the handshake timing cannot honour.
  if (VALID_CYC < 2 || RESULT_LAT < 1 || TIMEOUT < 1 ||
      NUM_CLASSES > (1 << CLASS_W)) begin : g_bad_cfg
    $error("har_frame_loader: unsupported parameter set");
  end

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic             beat;

`ifdef HAR_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  logic [TMO_W-1:0] tmo_cnt;
`endif

  assign beat     = bus.s_valid & bus.s_ready;
  assign bus.busy = !(state == LOAD && idx == '0);

  // Frame control: state, beat index, fire/wait counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= LOAD;
      idx           <= '0;
      cnt           <= '0;
      bus.s_ready   <= 1'b0;
      bus.v_valid   <= 1'b0;
      bus.m_valid   <= 1'b0;
      bus.m_class   <= '0;
      bus.frame_err <= 1'b0;
`ifdef HAR_TIMEOUT_EN
      tmo_cnt       <= '0;
`endif
    end else begin
      bus.frame_err <= 1'b0;
      case (state)
        LOAD: begin
          bus.s_ready <= 1'b1;
          if (beat) begin
`ifdef HAR_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
            if (idx == LAST_IDX) begin
              idx <= '0;
              if (bus.s_last) begin
                // Complete frame: stop accepting and strobe the classifier.
                state       <= FIRE;
                cnt         <= '0;
                bus.s_ready <= 1'b0;
              end else begin
                // Frame overran: discard until the producer's s_last.
                bus.frame_err <= 1'b1;
                state         <= DROP;
              end
            end else if (bus.s_last) begin
              // Short frame: restart collection from word 0.
              bus.frame_err <= 1'b1;
              idx           <= '0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
`ifdef HAR_TIMEOUT_EN
          else if (idx == '0) begin
            tmo_cnt <= '0;
          end else if (tmo_cnt == TMO_LAST) begin
            bus.frame_err <= 1'b1;
            idx           <= '0;
            tmo_cnt       <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
`endif
        end
        DROP: begin
          bus.s_ready <= 1'b1;
          if (beat && bus.s_last) state <= LOAD;
        end
        FIRE: begin
          // First FIRE cycle raises v_valid; it then stays up VALID_CYC cycles.
          if (cnt == FIRE_LAST) begin
            bus.v_valid <= 1'b0;
            cnt         <= '0;
            state       <= WAIT;
          end else begin
            bus.v_valid <= 1'b1;
            cnt         <= cnt + CNT_W'(1);
          end
        end
        WAIT: begin
          if (cnt == WAIT_LAST) begin
            bus.m_class <= bus.class_in;
            bus.m_valid <= 1'b1;
            state       <= OUT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        OUT: begin
          if (bus.m_ready) begin
            bus.m_valid <= 1'b0;
            bus.s_ready <= 1'b1;
            state       <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Image store: only accepted LOAD beats write; contents persist otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.image <= '0;
    end else if (beat && state == LOAD) begin
      bus.image[idx] <= bus.s_data;
    end
  end

endmodule

// File: tb/tb_har_frame_loader.sv
// Self-checking bench for har_frame_loader: table of frame scenarios plus
// hand-written sequences for result stall, reset during FIRE and stall timeout.
module tb_har_frame_loader;
  import har_pkg::*;

  localparam int IMG = 95;
  localparam int MSB = 15;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  har_frame_loader_if #(.IMG_SIZE(IMG), .M(MSB)) bus ();

  har_frame_loader #(
    .IMG_SIZE(IMG), .NUM_CLASSES(6), .M(MSB),
    .VALID_CYC(2), .RESULT_LAT(1), .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  int err_cnt  = 0;
  int vv_cnt   = 0;

  // Count pulse cycles away from the active edge.
  always @(negedge clk) begin
    if (bus.frame_err) err_cnt++;
    if (bus.v_valid)   vv_cnt++;
  end

  typedef struct {
    int          nbeats;
    int          last_pos;
    logic [15:0] seed;
    logic [3:0]  cls;
    int          exp_err;
    bit          exp_res;
    bit          chk_img;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    int n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = l;
    while (!bus.s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=%0d required=<100", n);
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic chk_image(input string name, input logic [15:0] seed);
    int bad = 0;
    for (int i = 0; i < IMG; i++)
      if (bus.image[i] !== 16'(seed + 16'(i))) bad++;
    chk(name, bad, 0);
  endtask

  task automatic wait_mvalid(output int lat);
    lat = 0;
    while (!bus.m_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int e0, vv0, lat;
    e0 = err_cnt;
    vv0 = vv_cnt;
    bus.class_in = v.cls;
    for (int i = 0; i < v.nbeats; i++)
      send(16'(v.seed + 16'(i)), i == v.last_pos);
    if (v.exp_res) begin
      wait_mvalid(lat);
      chk($sformatf("v%0d_latency", n), lat, 4);
      chk($sformatf("v%0d_m_class", n), bus.m_class, v.cls);
      chk($sformatf("v%0d_vvalid_cycles", n), vv_cnt - vv0, 2);
      chk($sformatf("v%0d_s_ready_out", n), bus.s_ready, 0);
      if (v.chk_img) chk_image($sformatf("v%0d_image", n), v.seed);
      bus.m_ready = 1'b1;
      @(negedge clk);
      bus.m_ready = 1'b0;
      chk($sformatf("v%0d_m_valid_after_hs", n), bus.m_valid, 0);
      chk($sformatf("v%0d_s_ready_after_hs", n), bus.s_ready, 1);
    end else begin
      repeat (8) @(negedge clk);
      chk($sformatf("v%0d_no_result", n), bus.m_valid, 0);
      chk($sformatf("v%0d_no_vvalid", n), vv_cnt - vv0, 0);
      if (v.chk_img) chk_image($sformatf("v%0d_image", n), v.seed);
    end
    chk($sformatf("v%0d_frame_err", n), err_cnt - e0, v.exp_err);
    chk($sformatf("v%0d_idle", n), bus.busy, 0);
  endtask

  initial begin
    int  lat, e0, vv0;
    bit  stable, seen;

    //        nbeats last  seed      cls    err res img
    vecs[0] = '{95,  94,  16'h0000, 4'd3, 0,  1,  1};
    vecs[1] = '{11,  10,  16'h0500, 4'd1, 1,  0,  0};
    vecs[2] = '{95,  94,  16'h1000, 4'd5, 0,  1,  1};
    vecs[3] = '{100, 99,  16'h2000, 4'd2, 1,  0,  1};
    vecs[4] = '{95,  94,  16'hFFC0, 4'd0, 0,  1,  1};

    bus.s_valid  = 1'b0;
    bus.s_data   = '0;
    bus.s_last   = 1'b0;
    bus.class_in = '0;
    bus.m_ready  = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_v_valid", bus.v_valid, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_class", bus.m_class, 0);
    chk("rst_frame_err", bus.frame_err, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_image_zero", bus.image == '0, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_s_ready", bus.s_ready, 1);

    foreach (vecs[k]) run_vec(vecs[k], k);

    // Result held while the consumer stalls.
    bus.class_in = 4'd9;
    for (int i = 0; i < IMG; i++) send(16'(16'd100 + 16'(i)), i == IMG - 1);
    wait_mvalid(lat);
    chk("stall_latency", lat, 4);
    bus.class_in = 4'd2;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.m_valid || bus.m_class !== 4'd9 || bus.s_ready) stable = 1'b0;
    end
    chk("stall_stable", stable, 1);
    bus.m_ready = 1'b1;
    @(negedge clk);
    bus.m_ready = 1'b0;
    chk("stall_m_valid_drop", bus.m_valid, 0);
    chk("stall_s_ready_rise", bus.s_ready, 1);
    chk("stall_m_class_kept", bus.m_class, 9);

    // Asynchronous reset while the classifier strobe is up.
    bus.class_in = 4'd4;
    for (int i = 0; i < IMG; i++) send(16'(16'd200 + 16'(i)), i == IMG - 1);
    @(negedge clk);
    chk("fire_v_valid", bus.v_valid, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_v_valid", bus.v_valid, 0);
    chk("arst_m_valid", bus.m_valid, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_s_ready", bus.s_ready, 0);
    chk("arst_image_zero", bus.image == '0, 1);
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.m_valid || bus.v_valid) seen = 1'b1;
    end
    chk("arst_no_result", seen, 0);

    // Stalled partial frame.
    for (int i = 0; i < 3; i++) send(16'(16'd300 + 16'(i)), 1'b0);
    e0 = err_cnt;
    vv0 = vv_cnt;
    repeat (7) @(negedge clk);
    chk("tmo_not_early", err_cnt - e0, 0);
    repeat (3) @(negedge clk);
`ifdef HAR_TIMEOUT_EN
    chk("tmo_frame_err", err_cnt - e0, 1);
    chk("tmo_idx_cleared", bus.busy, 0);
`else
    chk("tmo_frame_err", err_cnt - e0, 0);
    chk("tmo_still_pending", bus.busy, 1);
`endif
    chk("tmo_no_vvalid", vv_cnt - vv0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=stuck required=finish");
    $fatal(1);
  end

endmodule
